game_actor_mover: RTL and testbench

Parametrised per-frame movement engine for one maze actor (Pac-Man or a ghost) on the 60 Hz game tick. Tracks pixel position, heading and a one-entry turn queue. Moves at a fractional speed via a phase accumulator, and gates turns and stops against the four neighbour tiles supplied by the maze RAM. Feeds the sprite renderer (position, heading, animation frame) and the pellet/collision logic (tile coordinates, tile-centre pulse).

---
 rtl/game_actor_mover.sv | 167 ++++++++++++++++
 tb/tb_game_actor_mover.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/game_actor_mover.sv
// Per-frame movement engine for one maze actor: position, heading, turn queue and animation.
// Define GAME_ACTOR_TUNNEL_EN to wrap x at the maze edges instead of saturating.
module game_actor_mover #(
  parameter int          TILE_SHIFT    = 3,
  parameter int          Y_TILE_OFFSET = 3,
  parameter int          START_X       = 119,
  parameter int          START_Y       = 227,
  parameter logic [1:0]  START_DIR     = 2'b00,
  parameter int          SPEED_W       = 8,
  parameter int          BLOCK_GH      = 1,
  parameter int          ANIM_DIV      = 2,
  parameter int          MAZE_W_PX     = 224
) (
  input  logic                 clk60,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 freeze,
  input  logic [SPEED_W:0]     speed,
  input  logic                 req_valid,
  input  logic [1:0]           req_dir,
  input  logic [3:0][1:0]      tile_info,
  output logic [8:0]           xloc,
  output logic [8:0]           yloc,
  output logic [1:0]           dir,
  output logic [5:0]           curr_xtile,
  output logic [5:0]           curr_ytile,
  output logic                 moving,
  output logic                 tile_centre,
  output logic [1:0]           anim_cycle
);

  localparam logic [1:0] DIR_R = 2'b00;
  localparam logic [1:0] DIR_U = 2'b01;
  localparam logic [1:0] DIR_D = 2'b10;
  localparam logic [1:0] DIR_L = 2'b11;

  localparam int                    CTR    = (1 << (TILE_SHIFT - 1)) - 1;
  localparam logic [TILE_SHIFT-1:0] CTR_L  = CTR[TILE_SHIFT-1:0];
  localparam logic [SPEED_W+1:0]    ONE_PX = (SPEED_W + 2)'(1) << SPEED_W;
  localparam logic [8:0]            X_MAX  = 9'(MAZE_W_PX - 1);
  localparam int                    SUB_W  = $clog2(ANIM_DIV + 1);

  logic [SPEED_W-1:0] acc;
  logic [SPEED_W+1:0] spd_clamped, sum, sum_rem;
  logic               step, active, centre, centre_n, moved, consume;
  logic [1:0]         queue, dir_n;
  logic               q_valid;
  logic [8:0]         x_n, y_n;
  logic [SUB_W-1:0]   sub_cnt, sub_inc;

  function automatic logic blocked(input logic [1:0] cls);
    return (cls == 2'b00) || ((BLOCK_GH != 0) && (cls == 2'b11));
  endfunction

  assign active      = enable & ~freeze & ~reset;
  assign spd_clamped = ({1'b0, speed} > ONE_PX) ? ONE_PX : {1'b0, speed};
  assign sum         = {2'b00, acc} + spd_clamped;
  assign step        = (sum >= ONE_PX);
  assign sum_rem     = step ? (sum - ONE_PX) : sum;
  assign centre      = (xloc[TILE_SHIFT-1:0] == CTR_L) && (yloc[TILE_SHIFT-1:0] == CTR_L);
  assign centre_n    = (x_n[TILE_SHIFT-1:0] == CTR_L) && (y_n[TILE_SHIFT-1:0] == CTR_L);
  assign sub_inc     = sub_cnt + SUB_W'(1);

  assign curr_xtile = 6'(xloc >> TILE_SHIFT);
  assign curr_ytile = 6'((yloc >> TILE_SHIFT) - 9'(Y_TILE_OFFSET));

  // Turn decision uses the queue as it stood before this edge.
  always_comb begin
    dir_n   = dir;
    consume = 1'b0;
    if (active && q_valid) begin
      if (queue == ~dir) begin
        dir_n   = queue;
        consume = 1'b1;
      end else if (centre && !blocked(tile_info[queue])) begin
        dir_n   = queue;
        consume = 1'b1;
      end
    end
  end

  always_comb begin
    x_n   = xloc;
    y_n   = yloc;
    moved = 1'b0;
    if (active && step && !(centre && blocked(tile_info[dir_n]))) begin
      case (dir_n)
        DIR_R: begin
          if (xloc == X_MAX) begin
`ifdef GAME_ACTOR_TUNNEL_EN
            x_n   = 9'd0;
            moved = 1'b1;
`endif
          end else begin
            x_n   = xloc + 9'd1;
            moved = 1'b1;
          end
        end
        DIR_L: begin
          if (xloc == 9'd0) begin
`ifdef GAME_ACTOR_TUNNEL_EN
            x_n   = X_MAX;
            moved = 1'b1;
`endif
          end else begin
            x_n   = xloc - 9'd1;
            moved = 1'b1;
          end
        end
        DIR_U: begin
          y_n   = yloc - 9'd1;
          moved = 1'b1;
        end
        default: begin
          y_n   = yloc + 9'd1;
          moved = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk60) begin
    if (reset) begin
      xloc        <= 9'(START_X);
      yloc        <= 9'(START_Y);
      dir         <= START_DIR;
      queue       <= 2'b00;
      q_valid     <= 1'b0;
      acc         <= '0;
      moving      <= 1'b0;
      tile_centre <= 1'b0;
      anim_cycle  <= 2'd1;
      sub_cnt     <= '0;
    end else begin
      // A fresh request overrides the consumption of the old one.
      if (req_valid) begin
        queue   <= req_dir;
        q_valid <= 1'b1;
      end else if (consume) begin
        q_valid <= 1'b0;
      end

      if (active) begin
        dir         <= dir_n;
        xloc        <= x_n;
        yloc        <= y_n;
        acc         <= SPEED_W'(sum_rem);
        moving      <= moved;
        tile_centre <= moved & centre_n;
        if (moved) begin
          if (sub_inc == SUB_W'(ANIM_DIV)) begin
            sub_cnt    <= '0;
            anim_cycle <= anim_cycle + 2'd1;
          end else begin
            sub_cnt <= sub_inc;
          end
        end else if (anim_cycle == 2'd0) begin
          anim_cycle <= 2'd1;
        end
      end else begin
        moving      <= 1'b0;
        tile_centre <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_actor_mover.sv
// Directed bench for game_actor_mover: a vector table walked frame by frame plus edge/reset sequences.
module tb_game_actor_mover;

  logic            clk60 = 1'b0;
  logic            reset, enable, freeze, req_valid;
  logic [8:0]      speed;
  logic [1:0]      req_dir;
  logic [3:0][1:0] tile_info;
  logic [8:0]      xloc, yloc;
  logic [1:0]      dir, anim_cycle;
  logic [5:0]      curr_xtile, curr_ytile;
  logic            moving, tile_centre;

  int n_pass = 0;
  int n_total = 0;

  game_actor_mover dut (
    .clk60(clk60), .reset(reset), .enable(enable), .freeze(freeze), .speed(speed),
    .req_valid(req_valid), .req_dir(req_dir), .tile_info(tile_info),
    .xloc(xloc), .yloc(yloc), .dir(dir), .curr_xtile(curr_xtile), .curr_ytile(curr_ytile),
    .moving(moving), .tile_centre(tile_centre), .anim_cycle(anim_cycle)
  );

  always #5 clk60 = ~clk60;

  typedef struct {
    logic       en, frz;
    logic [8:0] spd;
    logic       rv;
    logic [1:0] rd;
    logic [7:0] ti;
    logic [8:0] x, y;
    logic [1:0] d;
    logic       mv, tc;
    logic [1:0] an;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic frz, input logic [8:0] spd,
                              input logic rv, input logic [1:0] rd, input logic [7:0] ti,
                              input logic [8:0] x, input logic [8:0] y, input logic [1:0] d,
                              input logic mv, input logic tc, input logic [1:0] an);
    vec_t v;
    v.en = en; v.frz = frz; v.spd = spd; v.rv = rv; v.rd = rd; v.ti = ti;
    v.x = x; v.y = y; v.d = d; v.mv = mv; v.tc = tc; v.an = an;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, " xloc"}, int'(xloc), x);
    chk({tag, " yloc"}, int'(yloc), y);
    chk({tag, " xtile"}, int'(curr_xtile), (x >> 3) & 63);
    chk({tag, " ytile"}, int'(curr_ytile), ((y >> 3) - 3) & 63);
  endtask

  task automatic tick;
    @(posedge clk60);
    #1;
  endtask

  localparam logic [7:0] T_OPEN = 8'h55;  // all neighbours empty
  localparam logic [7:0] T_RW   = 8'h54;  // wall to the right
  localparam logic [7:0] T_LGH  = 8'hD4;  // wall right, ghost house left

  initial begin
    reset = 1'b1; enable = 1'b0; freeze = 1'b0; req_valid = 1'b0; req_dir = 2'd0;
    speed = 9'd0; tile_info = T_OPEN;

    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_OPEN, 9'd120,9'd227,2'd0,1'b1,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_OPEN, 9'd121,9'd227,2'd0,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_OPEN, 9'd122,9'd227,2'd0,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_OPEN, 9'd123,9'd227,2'd0,1'b1,1'b1,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd227,2'd0,1'b0,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b1,2'd1,T_RW,   9'd123,9'd227,2'd0,1'b0,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd226,2'd1,1'b1,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd225,2'd1,1'b1,1'b0,2'd0));
    vecs.push_back(mk(1'b0,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd225,2'd1,1'b0,1'b0,2'd0));
    vecs.push_back(mk(1'b1,1'b0,9'd0,  1'b0,2'd0,T_RW,   9'd123,9'd225,2'd1,1'b0,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b1,2'd2,T_RW,   9'd123,9'd224,2'd1,1'b1,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd225,2'd2,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd226,2'd2,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd227,2'd2,1'b1,1'b1,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd227,2'd2,1'b0,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd300,1'b0,2'd0,T_RW,   9'd123,9'd228,2'd2,1'b1,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd300,1'b0,2'd0,T_RW,   9'd123,9'd229,2'd2,1'b1,1'b0,2'd0));
    vecs.push_back(mk(1'b1,1'b0,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd230,2'd2,1'b1,1'b0,2'd0));
    vecs.push_back(mk(1'b1,1'b0,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd230,2'd2,1'b0,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd64, 1'b0,2'd0,T_RW,   9'd123,9'd230,2'd2,1'b0,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd64, 1'b0,2'd0,T_RW,   9'd123,9'd231,2'd2,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd231,2'd2,1'b0,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b1,9'd128,1'b1,2'd3,T_RW,   9'd123,9'd231,2'd2,1'b0,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b1,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd231,2'd2,1'b0,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b1,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd231,2'd2,1'b0,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd232,2'd2,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd128,1'b0,2'd0,T_RW,   9'd123,9'd232,2'd2,1'b0,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd233,2'd2,1'b1,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd234,2'd2,1'b1,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd123,9'd235,2'd2,1'b1,1'b1,2'd0));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd122,9'd235,2'd3,1'b1,1'b0,2'd0));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd121,9'd235,2'd3,1'b1,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd120,9'd235,2'd3,1'b1,1'b0,2'd1));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd119,9'd235,2'd3,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd118,9'd235,2'd3,1'b1,1'b0,2'd2));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd117,9'd235,2'd3,1'b1,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd116,9'd235,2'd3,1'b1,1'b0,2'd3));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_RW,   9'd115,9'd235,2'd3,1'b1,1'b1,2'd0));
    vecs.push_back(mk(1'b1,1'b0,9'd256,1'b0,2'd0,T_LGH,  9'd115,9'd235,2'd3,1'b0,1'b0,2'd1));

    tick;
    tick;
    chk_pos("reset", 119, 227);
    chk("reset dir", int'(dir), 0);
    chk("reset moving", int'(moving), 0);
    chk("reset tile_centre", int'(tile_centre), 0);
    chk("reset anim", int'(anim_cycle), 1);

    reset = 1'b0;
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      enable = vecs[i].en; freeze = vecs[i].frz; speed = vecs[i].spd;
      req_valid = vecs[i].rv; req_dir = vecs[i].rd; tile_info = vecs[i].ti;
      tick;
      chk_pos(tag, int'(vecs[i].x), int'(vecs[i].y));
      chk({tag, " dir"}, int'(dir), int'(vecs[i].d));
      chk({tag, " moving"}, int'(moving), int'(vecs[i].mv));
      chk({tag, " tile_centre"}, int'(tile_centre), int'(vecs[i].tc));
      chk({tag, " anim"}, int'(anim_cycle), int'(vecs[i].an));
    end

    // Run left to the maze edge, then take one more step into it.
    begin
      bit reached;
      reached = 1'b0;
      enable = 1'b1; freeze = 1'b0; speed = 9'd256; req_valid = 1'b0; tile_info = T_OPEN;
      for (int k = 0; k < 200 && !reached; k++) begin
        tick;
        if (xloc == 9'd0) reached = 1'b1;
      end
      chk("edge reached x0", int'(reached), 1);
      tick;
`ifdef GAME_ACTOR_TUNNEL_EN
      chk_pos("tunnel wrap", 223, 235);
      chk("tunnel moving", int'(moving), 1);
      tick;
      chk_pos("tunnel after", 222, 235);
`else
      chk_pos("edge hold", 0, 235);
      chk("edge moving", int'(moving), 0);
      req_valid = 1'b1; req_dir = 2'd0;
      tick;
      req_valid = 1'b0;
      chk_pos("edge req", 0, 235);
      tick;
      chk("edge reverse dir", int'(dir), 0);
      chk_pos("edge reverse", 1, 235);
`endif
    end

    // Reset must also swallow a simultaneous request.
    reset = 1'b1; req_valid = 1'b1; req_dir = 2'd1;
    tick;
    chk_pos("midreset", 119, 227);
    chk("midreset dir", int'(dir), 0);
    chk("midreset moving", int'(moving), 0);
    chk("midreset anim", int'(anim_cycle), 1);
    reset = 1'b0; req_valid = 1'b0; enable = 1'b1; speed = 9'd256; tile_info = T_OPEN;
    repeat (4) tick;
    chk_pos("postreset centre", 123, 227);
    chk("postreset tile_centre", int'(tile_centre), 1);
    tick;
    chk_pos("postreset pass", 124, 227);
    chk("postreset dir", int'(dir), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
